// File: rtl/uart_rx_os_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Defining UART_RX_PARITY_EN adds the PARITY state usage in uart_rx_os.
package uart_rx_os_pkg;

    localparam int unsigned UART_RX_MIN_BAUD = 3;
    localparam int unsigned DATA_W           = 8;
    localparam int unsigned CNT_W            = 32;
    localparam int unsigned BIT_IDX_W        = 3;

    typedef enum logic [2:0] {
        UART_RX_IDLE   = 3'd0,
        UART_RX_START  = 3'd1,
        UART_RX_DATA   = 3'd2,
        UART_RX_STOP   = 3'd3,
        UART_RX_PARITY = 3'd4
    } uart_rx_state_e;

    // Even parity bit: makes the total count of ones in byte + parity even.
    function automatic logic even_parity(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_rx_os_sync_ff.sv
// N-flop synchronizer with reset value 1 (UART line idle level).
module sync_ff #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_q;
    logic [N-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[N-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[N-1];

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing/overrun flags, valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx_os
    import uart_rx_os_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic [CNT_W-1:0]  baud_div,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err,
`endif
    input  logic              err_clr,
    output logic              busy
);

    logic rx_s;
    logic rx_s_d_q;

    sync_ff #(.N(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    uart_rx_state_e        state_q,     state_d;
    logic [CNT_W-1:0]      bdiv_q,      bdiv_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [BIT_IDX_W-1:0]  bit_idx_q,   bit_idx_d;
    logic [DATA_W-1:0]     shreg_q,     shreg_d;
    logic [DATA_W-1:0]     rx_data_q,   rx_data_d;
    logic                  rx_valid_q,  rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q,   overrun_d;
    logic                  busy_q,      busy_d;
    logic                  parity_good_c;
    logic                  byte_done_c;
`ifdef UART_RX_PARITY_EN
    logic                  parity_ok_q,  parity_ok_d;
    logic                  parity_err_q, parity_err_d;
    assign parity_good_c = parity_ok_q;
`else
    assign parity_good_c = 1'b1;
`endif

    // Next-state, datapath and handshake logic.
    always_comb begin
        state_d     = state_q;
        bdiv_d      = bdiv_q;
        cnt_d       = (state_q == UART_RX_IDLE) ? '0 : CNT_W'(cnt_q + CNT_W'(1));
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = err_clr ? 1'b0 : frame_err_q;
        overrun_d   = err_clr ? 1'b0 : overrun_q;
        byte_done_c = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_ok_d  = parity_ok_q;
        parity_err_d = err_clr ? 1'b0 : parity_err_q;
`endif

        case (state_q)
            UART_RX_IDLE: begin
                if (rx_s_d_q && !rx_s) begin
                    state_d = UART_RX_START;
                    bdiv_d  = baud_div;
                end
            end
            UART_RX_START: begin
                if (cnt_q == (bdiv_q >> 1)) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = UART_RX_DATA;
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        parity_ok_d = 1'b1;
`endif
                    end else begin
                        state_d = UART_RX_IDLE;
                    end
                end
            end
            UART_RX_DATA: begin
                if (cnt_q == bdiv_q) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s, shreg_q[DATA_W-1:1]};
                    bit_idx_d = BIT_IDX_W'(bit_idx_q + BIT_IDX_W'(1));
                    if (bit_idx_q == BIT_IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = UART_RX_PARITY;
`else
                        state_d = UART_RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            UART_RX_PARITY: begin
                if (cnt_q == bdiv_q) begin
                    cnt_d   = '0;
                    state_d = UART_RX_STOP;
                    if (rx_s != even_parity(shreg_q)) begin
                        parity_ok_d  = 1'b0;
                        parity_err_d = 1'b1;
                    end
                end
            end
`endif
            UART_RX_STOP: begin
                if (cnt_q == bdiv_q) begin
                    cnt_d   = '0;
                    state_d = UART_RX_IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end else if (parity_good_c) begin
                        byte_done_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = UART_RX_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        // A completing byte may only replace the held one if it is consumed this cycle.
        if (byte_done_c) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != UART_RX_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s_d_q    <= 1'b1;
            state_q     <= UART_RX_IDLE;
            bdiv_q      <= '0;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_ok_q  <= 1'b1;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_s_d_q    <= rx_s;
            state_q     <= state_d;
            bdiv_q      <= bdiv_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            parity_ok_q  <= parity_ok_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed self-checking bench for uart_rx_os (8N1, baud_div=15, SYNC_STAGES=2).
// Parity scenarios run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;

    localparam int BDIV = 15;
    localparam int BIT  = BDIV + 1;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [31:0] baud_div;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun;
    logic        err_clr;
    logic        busy;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif

    int checks;
    int errors;
    logic [7:0] cap_q[$];

    uart_rx_os #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .baud_div  (baud_div),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .err_clr   (err_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake; ready changes only #1 after posedge so this sees stable values.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) cap_q.push_back(rx_data);
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic use_par,
                              input logic par_bit, input logic stop_bit);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        if (use_par) drive_bit(par_bit);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic accept_one();
        @(posedge clk); #1 rx_ready = 1'b1;
        @(posedge clk); #1 rx_ready = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_basic();
        cap_q.delete();
        rx_ready = 1'b0;
        fork
            send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                @(negedge clk);
                @(posedge clk);                  // edge E
                repeat (153) @(posedge clk);
                #1;
                checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early got %b exp 0 at E+153", rx_valid); end
                @(posedge clk);
                #1;
                checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_latency got %b exp 1 at E+154", rx_valid); end
            end
        join
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", rx_data); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL basic_flags got fe=%b ov=%b exp 0 0", frame_err, overrun); end
        accept_one();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_accept_valid got %b exp 0", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data_held got %h exp a5", rx_data); end
        checks++; if (cap_q.size() !== 1) begin errors++; $display("FAIL basic_handshakes got %0d exp 1", cap_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        cap_q.delete();
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b0, 1'b0, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        checks++; if (cap_q.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", cap_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < cap_q.size()) begin
                checks++; if (cap_q[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, cap_q[i], exp_b[i]); end
            end
        end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_flags got fe=%b ov=%b v=%b exp 0 0 0", frame_err, overrun, rx_valid); end
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun();
        cap_q.delete();
        rx_ready = 1'b0;
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        send_frame(8'h34, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", rx_valid); end
        checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL ovr_data_kept got %h exp 12", rx_data); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ovr_frame_err got %b exp 0", frame_err); end
        clear_errs();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", overrun); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_after_clr got %b exp 1", rx_valid); end
        accept_one();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept got %b exp 0", rx_valid); end
        checks++; if (cap_q.size() !== 1 || cap_q[0] !== 8'h12) begin
            errors++; $display("FAIL ovr_accept_data got n=%0d d=%h exp n=1 d=12", cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 8'hxx); end
    endtask

    task automatic test_framing();
        cap_q.delete();
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_flag got %b exp 1", frame_err); end
        checks++; if (rx_valid !== 1'b0 || cap_q.size() !== 0) begin
            errors++; $display("FAIL frame_no_byte got v=%b n=%0d exp 0 0", rx_valid, cap_q.size()); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL frame_overrun got %b exp 0", overrun); end
        clear_errs();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_clr got %b exp 0", frame_err); end
    endtask

    task automatic test_glitch();
        cap_q.delete();
        rx_ready = 1'b1;
        @(negedge clk) rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high got %b exp 1", busy); end
        repeat (2 * BIT) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low got %b exp 0", busy); end
        checks++; if (cap_q.size() !== 0 || rx_valid !== 1'b0) begin
            errors++; $display("FAIL glitch_no_byte got n=%0d v=%b exp 0 0", cap_q.size(), rx_valid); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL glitch_flags got fe=%b ov=%b exp 0 0", frame_err, overrun); end
    endtask

    task automatic test_reset_mid_frame();
        cap_q.delete();
        rx_ready = 1'b1;
        fork
            send_frame(8'h81, 1'b0, 1'b0, 1'b1);
            begin
                @(negedge clk);
                repeat (5 * BIT + BIT / 2) @(negedge clk);  // middle of data bit 4
                rst_n = 1'b0;
                #1;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
            end
        join
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        checks++; if (cap_q.size() !== 1 || cap_q[0] !== 8'h7E) begin
            errors++; $display("FAIL rstmid_data got n=%0d d=%h exp n=1 d=7e", cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 8'hxx); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags got fe=%b ov=%b exp 0 0", frame_err, overrun); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        cap_q.delete();
        rx_ready = 1'b1;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        checks++; if (cap_q.size() !== 1 || cap_q[0] !== 8'h03) begin
            errors++; $display("FAIL par_good got n=%0d d=%h exp n=1 d=03", cap_q.size(), (cap_q.size() > 0) ? cap_q[0] : 8'hxx); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good_flag got %b exp 0", parity_err); end
        cap_q.delete();
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_flag got %b exp 1", parity_err); end
        checks++; if (cap_q.size() !== 0) begin errors++; $display("FAIL par_bad_no_byte got n=%0d exp 0", cap_q.size()); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_frame_err got %b exp 0", frame_err); end
        clear_errs();
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_clr got %b exp 0", parity_err); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        rx       = 1'b1;
        baud_div = 32'(BDIV);
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_basic();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_glitch();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
